ex_alu_muldiv: RTL and testbench

//  Execute stage placed directly downstream of the ID/EX pipeline register; consumes its ALU control, operands and immediate.

---
 rtl/ex_alu_muldiv.sv | 172 +++++++++++++++++
 tb/tb_ex_alu_muldiv.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_alu_muldiv.sv
// Execute stage: single-cycle ALU with zero flag, HI/LO registers and an
// iterative 32-step MULT/MULTU/DIV/DIVU engine that stalls the upstream pipe.
module ex_alu_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Function,
  input  logic             ALUSrc,
  input  logic [WIDTH-1:0] dataRs,
  input  logic [WIDTH-1:0] dataRt,
  input  logic [WIDTH-1:0] Immediate,
  input  logic             flush,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned DW = 2 * WIDTH;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU = 6'h2B;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DW-1:0]      acc;
  logic [WIDTH-1:0]   dvsr;
  logic               op_div, neg_res, neg_rem, div0;

  logic [WIDTH-1:0]   op_b;
  logic [CNT_W-1:0]   shamt, shvar;
  logic               rtype, md_op, start, mt_hi, mt_lo;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     sum, shifted, diff;
  logic [DW-1:0]      step, prod;
  logic [WIDTH-1:0]   quo, rem, fin_hi, fin_lo;

  // Single-cycle ALU
  always_comb begin
    op_b       = ALUSrc ? Immediate : dataRt;
    shamt      = Immediate[10:6];
    shvar      = dataRs[CNT_W-1:0];
    alu_result = '0;
    case (ALUOp)
      2'b00:   alu_result = dataRs + op_b;
      2'b01:   alu_result = dataRs - op_b;
      2'b11:   alu_result = dataRs | op_b;
      default: begin
        case (Function)
          F_ADD, F_ADDU: alu_result = dataRs + op_b;
          F_SUB, F_SUBU: alu_result = dataRs - op_b;
          F_AND:         alu_result = dataRs & op_b;
          F_OR:          alu_result = dataRs | op_b;
          F_XOR:         alu_result = dataRs ^ op_b;
          F_NOR:         alu_result = ~(dataRs | op_b);
          F_SLT:         alu_result = WIDTH'($signed(dataRs) < $signed(op_b));
          F_SLTU:        alu_result = WIDTH'(dataRs < op_b);
          F_SLL:         alu_result = op_b << shamt;
          F_SRL:         alu_result = op_b >> shamt;
          F_SRA:         alu_result = $signed(op_b) >>> shamt;
          F_SLLV:        alu_result = op_b << shvar;
          F_SRLV:        alu_result = op_b >> shvar;
          F_SRAV:        alu_result = $signed(op_b) >>> shvar;
          F_MFHI:        alu_result = hi;
          F_MFLO:        alu_result = lo;
          default:       alu_result = '0;
        endcase
      end
    endcase
    zero = (alu_result == '0);
  end

  // Decode and operand magnitudes; Function[1] selects divide, Function[0] unsigned
  always_comb begin
    rtype = (ALUOp == 2'b10);
    md_op = rtype && (Function[5:2] == 4'b0110);
    start = (state == IDLE) && md_op && !flush;
    mt_hi = rtype && (Function == F_MTHI) && !flush;
    mt_lo = rtype && (Function == F_MTLO) && !flush;
    neg_a = !Function[0] && dataRs[WIDTH-1];
    neg_b = !Function[0] && dataRt[WIDTH-1];
    abs_a = neg_a ? -dataRs : dataRs;
    abs_b = neg_b ? -dataRt : dataRt;
  end

  // One shift-add or restoring-subtract step; acc holds {acc_hi/rem, multiplier/quotient}
  always_comb begin
    sum     = {1'b0, acc[DW-1:WIDTH]} + (acc[0] ? {1'b0, dvsr} : {(WIDTH+1){1'b0}});
    shifted = {acc[DW-1:WIDTH], acc[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr};
    if (op_div) begin
      step = diff[WIDTH] ? {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                         : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      step = {sum, acc[WIDTH-1:1]};
    end
    prod = neg_res ? -step : step;
    quo  = step[WIDTH-1:0];
    rem  = step[DW-1:WIDTH];
    if (op_div) begin
      fin_lo = div0 ? '1 : (neg_res ? -quo : quo);
      fin_hi = neg_rem ? -rem : rem;
    end else begin
      fin_hi = prod[DW-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end
  end

  // Engine FSM with HI/LO; the final step lands in HI/LO on the BUSY->DONE edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      dvsr    <= '0;
      op_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      if (mt_hi) hi <= dataRs;
      if (mt_lo) lo <= dataRs;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= BUSY;
            cnt     <= '0;
            acc     <= {{WIDTH{1'b0}}, abs_a};
            dvsr    <= abs_b;
            op_div  <= Function[1];
            neg_res <= neg_a ^ neg_b;
            neg_rem <= neg_a;
            div0    <= (dataRt == '0);
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc <= step;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) begin
              hi    <= fin_hi;
              lo    <= fin_lo;
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state == BUSY);
  assign stall = start | busy;

endmodule

// File: tb/tb_ex_alu_muldiv.sv
// Bench for ex_alu_muldiv: ALU vector table plus scoreboarded mul/div,
// HI/LO moves, flush and asynchronous reset sequences.
module tb_ex_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ALUOp;
  logic [5:0]  Function;
  logic        ALUSrc;
  logic [31:0] dataRs, dataRt, Immediate;
  logic        flush;
  logic [31:0] alu_result, hi, lo;
  logic        zero, stall, busy;

  int total = 0;
  int bad   = 0;
  logic [31:0] hi_m, lo_m;

  typedef struct {
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        alu_src;
    logic [31:0] rs, rt, imm, exp_res;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
  } md_exp_t;

  vec_t        vecs[22];
  md_exp_t     md_q[$];
  logic [31:0] alu_q[$];

  ex_alu_muldiv #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Function(Function), .ALUSrc(ALUSrc),
    .dataRs(dataRs), .dataRt(dataRt), .Immediate(Immediate), .flush(flush),
    .alu_result(alu_result), .zero(zero), .stall(stall), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic src,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                       input logic fl);
    ALUOp = op; Function = f; ALUSrc = src;
    dataRs = rs; dataRt = rt; Immediate = imm; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one mul/div, count stall cycles, check HI/LO in DONE and via MFHI/MFLO
  task automatic run_md(input string name, input logic [5:0] f, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] eh, input logic [31:0] el);
    md_exp_t e;
    int n;
    bit done;
    e.hi = eh; e.lo = el;
    md_q.push_back(e);
    drive(2'b10, f, 1'b0, rs, rt, 32'd0, 1'b0);
    #1;
    chk({name, " start_stall"}, 32'(stall), 32'd1);
    n = 1; done = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!stall) begin
        done = 1;
        break;
      end
      n++;
    end
    chk({name, " completed"}, 32'(done), 32'd1);
    chk({name, " stall_cycles"}, 32'(n), 32'd33);
    chk({name, " done_busy"}, 32'(busy), 32'd0);
    e = md_q.pop_front();
    chk({name, " hi"}, hi, e.hi);
    chk({name, " lo"}, lo, e.lo);
    hi_m = e.hi; lo_m = e.lo;
    drive(2'b10, 6'h10, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    #1;
    chk({name, " mfhi"}, alu_result, e.hi);
    drive(2'b10, 6'h12, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    #1;
    chk({name, " mflo"}, alu_result, e.lo);
    tick();
    chk({name, " no_restart"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{2'b10, 6'h2A, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd1};
    vecs[1]  = '{2'b10, 6'h2B, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0};
    vecs[2]  = '{2'b10, 6'h03, 1'b0, 32'd0,        32'h80000000, 32'h00000100, 32'hF8000000};
    vecs[3]  = '{2'b00, 6'h00, 1'b1, 32'd100,      32'd0,        32'hFFFFFFFC, 32'd96};
    vecs[4]  = '{2'b10, 6'h20, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0};
    vecs[5]  = '{2'b10, 6'h22, 1'b0, 32'd0,        32'd1,        32'd0,        32'hFFFFFFFF};
    vecs[6]  = '{2'b10, 6'h24, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'hF000F000};
    vecs[7]  = '{2'b10, 6'h25, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'hFFF0FFF0};
    vecs[8]  = '{2'b10, 6'h26, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'h0FF00FF0};
    vecs[9]  = '{2'b10, 6'h27, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'h000F000F};
    vecs[10] = '{2'b10, 6'h00, 1'b0, 32'd0,        32'd1,        32'h000007C0, 32'h80000000};
    vecs[11] = '{2'b10, 6'h02, 1'b0, 32'd0,        32'h80000000, 32'h00000100, 32'h08000000};
    vecs[12] = '{2'b10, 6'h04, 1'b0, 32'h00000023, 32'd1,        32'd0,        32'd8};
    vecs[13] = '{2'b10, 6'h06, 1'b0, 32'h00000024, 32'hF0000000, 32'd0,        32'h0F000000};
    vecs[14] = '{2'b10, 6'h07, 1'b0, 32'hFFFFFFE4, 32'h80000000, 32'd0,        32'hF8000000};
    vecs[15] = '{2'b01, 6'h00, 1'b0, 32'd5,        32'd7,        32'd0,        32'hFFFFFFFE};
    vecs[16] = '{2'b11, 6'h00, 1'b1, 32'h0000000F, 32'd0,        32'h000000F0, 32'h000000FF};
    vecs[17] = '{2'b10, 6'h3F, 1'b0, 32'h12345678, 32'd1,        32'd0,        32'd0};
    vecs[18] = '{2'b10, 6'h21, 1'b1, 32'd7,        32'd100,      32'd3,        32'd10};
    vecs[19] = '{2'b10, 6'h2A, 1'b0, 32'd1,        32'hFFFFFFFF, 32'd0,        32'd0};
    vecs[20] = '{2'b10, 6'h23, 1'b0, 32'd10,       32'd3,        32'd0,        32'd7};
    vecs[21] = '{2'b10, 6'h10, 1'b0, 32'd5,        32'd5,        32'd0,        32'd0};

    rst_n = 1'b0;
    drive(2'b00, 6'h00, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    hi_m = '0; lo_m = '0;
    #12;
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 22; i++) begin
      logic [31:0] exp;
      drive(vecs[i].alu_op, vecs[i].funct, vecs[i].alu_src, vecs[i].rs, vecs[i].rt, vecs[i].imm, 1'b0);
      alu_q.push_back(vecs[i].exp_res);
      #1;
      exp = alu_q.pop_front();
      chk($sformatf("alu[%0d] result", i), alu_result, exp);
      chk($sformatf("alu[%0d] zero", i), 32'(zero), 32'(exp == 32'd0));
    end
    tick();

    run_md("mult_neg",   6'h18, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run_md("multu_max",  6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1);
    run_md("mult_pos",   6'h18, 32'h12345678, 32'h00000010, 32'd1,        32'h23456780);
    run_md("div_neg",    6'h1A, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("div_negdiv", 6'h1A, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
    run_md("divu_zero",  6'h1B, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);
    run_md("div_zero",   6'h1A, 32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 32'hFFFFFFFF);
    run_md("div_ovf",    6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000);
    run_md("divu_norm",  6'h1B, 32'd100,      32'd7,        32'd2,        32'd14);

    // MTLO right after the engine finishes, then MFLO
    drive(2'b10, 6'h13, 1'b0, 32'd5, 32'd0, 32'd0, 1'b0);
    tick();
    lo_m = 32'd5;
    drive(2'b10, 6'h12, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    #1;
    chk("mtlo_mflo", alu_result, 32'd5);
    drive(2'b10, 6'h11, 1'b0, 32'h0000ABCD, 32'd0, 32'd0, 1'b1);
    tick();
    chk("mthi_flushed", hi, hi_m);
    drive(2'b10, 6'h11, 1'b0, 32'h0000ABCD, 32'd0, 32'd0, 1'b0);
    tick();
    hi_m = 32'h0000ABCD;
    chk("mthi", hi, hi_m);

    // Flush mid-operation: back to IDLE, HI/LO untouched
    drive(2'b10, 6'h19, 1'b0, 32'd3, 32'd3, 32'd0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("flush pre_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush stall", 32'(stall), 32'd0);
    chk("flush hi", hi, hi_m);
    chk("flush lo", lo, lo_m);
    drive(2'b00, 6'h00, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    tick();

    // Asynchronous reset mid-operation
    drive(2'b10, 6'h18, 1'b0, 32'd5, 32'd6, 32'd0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("rst pre_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async busy", 32'(busy), 32'd0);
    chk("rst_async hi", hi, 32'd0);
    chk("rst_async lo", lo, 32'd0);
    drive(2'b00, 6'h00, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    #1;
    chk("rst_async stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_md("mult_after_rst", 6'h18, 32'd5, 32'd6, 32'd0, 32'd30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
